// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: nibble-serial adder reusing a single 4-bit ripple-carry datapath.
// Optional subtract mode (op port, ~b with initial carry 1) is enabled by defining SERIAL_ADD_SUB_EN.

// serial_add_fa: 1-bit full adder cell
module serial_add_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic                   op,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          cout_q, cout_d, busy_q, busy_d, done_q, done_d;
    logic [3:0]    nib_a, nib_b, nib_s;
    logic [4:0]    c;
    logic          last;

`ifdef SERIAL_ADD_SUB_EN
    logic          op_q, op_d;
    assign nib_b = b_q[{cnt_q, 2'b00} +: 4] ^ {4{op_q}};
`else
    assign nib_b = b_q[{cnt_q, 2'b00} +: 4];
`endif
    assign nib_a = a_q[{cnt_q, 2'b00} +: 4];
    assign last  = cnt_q == CW'(NIBBLES - 1);
    assign c[0]  = carry_q;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_fa
            serial_add_fa u_fa (
                .x (nib_a[i]),
                .y (nib_b[i]),
                .ci(c[i]),
                .s (nib_s[i]),
                .co(c[i+1])
            );
        end
    endgenerate

    // next-state: accept start outside RUN, otherwise step one nibble per cycle in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_SUB_EN
        op_d    = op_q;
`endif
        if (state_q == RUN) begin
            sum_d[{cnt_q, 2'b00} +: 4] = nib_s;
            carry_d = c[4];
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            if (last) begin
                state_d = DONE;
                cout_d  = c[4];
            end
        end else if (start) begin
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            cnt_d   = '0;
`ifdef SERIAL_ADD_SUB_EN
            op_d    = op;
            carry_d = op;
`else
            carry_d = 1'b0;
`endif
        end else begin
            state_d = IDLE;
        end
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    // state and registered outputs, asynchronously cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            op_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADD_SUB_EN
            op_q    <= op_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: vector table plus hand sequences for serial_add_ctrl (NIBBLES=4)
module tb_serial_add_ctrl;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] s;
        logic        c;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
`ifdef SERIAL_ADD_SUB_EN
    logic        op = 1'b0;
`endif
    logic        busy, done, cout;
    logic [15:0] sum;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];
    exp_t sb[$];

    serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .a      (a),
        .b      (b),
`ifdef SERIAL_ADD_SUB_EN
        .op     (op),
`endif
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_unexpected_done"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({name, "_sum"}, 32'(sum), 32'(e.s));
            check({name, "_cout"}, 32'(cout), 32'(e.c));
        end
    endtask

    task automatic run_op(input vec_t v);
        int bc = 0;
        int dn = 0;
        @(negedge clk);
        a = v.a;
        b = v.b;
`ifdef SERIAL_ADD_SUB_EN
        op = v.op;
`endif
        start = 1'b1;
        sb.push_back('{v.s, v.c});
        for (int n = 1; n <= 12 && dn == 0; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bc++;
            if (done) begin
                dn = n;
                sb_check("op");
            end
        end
        check("done_seen", 32'(dn != 0), 32'd1);
        check("latency", 32'(dn), 32'd5);
        check("busy_cycles", 32'(bc), 32'd5);
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1});
        vecs.push_back('{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0});
        vecs.push_back('{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1});
        vecs.push_back('{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1});
`endif

        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i]);

        // start held for 10 edges: back-to-back ops, one done per 5 cycles
        begin
            int dc = 0;
            @(negedge clk);
            a = 16'h00F0;
            b = 16'h0010;
`ifdef SERIAL_ADD_SUB_EN
            op = 1'b0;
`endif
            start = 1'b1;
            sb.push_back('{16'h0100, 1'b0});
            sb.push_back('{16'h0100, 1'b0});
            for (int n = 1; n <= 15; n++) begin
                @(negedge clk);
                if (n == 10) start = 1'b0;
                if (n == 6) check("held_busy_b2b", 32'(busy), 32'd1);
                if (done) begin
                    dc++;
                    check("held_done_pos", 32'(n), 32'(dc * 5));
                    sb_check("held");
                end
            end
            check("held_done_count", 32'(dc), 32'd2);
        end

        // reset during the 2nd RUN cycle kills the op without a done
        begin
            int dc = 0;
            @(negedge clk);
            a = 16'h0F0F;
            b = 16'h0101;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            reset_n = 1'b0;
            #1;
            check("arst_sum", 32'(sum), 32'd0);
            check("arst_cout", 32'(cout), 32'd0);
            check("arst_busy", 32'(busy), 32'd0);
            check("arst_done", 32'(done), 32'd0);
            @(negedge clk);
            reset_n = 1'b1;
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                if (done || busy) dc++;
            end
            check("arst_no_done", 32'(dc), 32'd0);
            run_op('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0});
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
